fpga_robots_game_ps2_rx: RTL and testbench
==========================================

# fpga_robots_game_ps2_rx

Receive-only PS/2 keyboard front end for the robots game. Sits between the top-level `ps2a_clk`/`ps2a_dat` pins and the game-play logic. It synchronizes and de-glitches both lines, then deframes 11-bit PS/2 device-to-host frames. Each received scan-code byte is delivered with a one-cycle strobe; malformed or stalled frames raise an error pulse. The game logic consumes its output; the block never drives the PS/2 lines.

## Interface
- `FILT_LEN`, default 8: consecutive identical samples required before a filtered line changes; range 2..15.
- `TIMEOUT_W`, default 17: width of the inter-edge timeout counter. A frame aborts after 2^TIMEOUT_W−1 cycles without a falling clock edge (~2 ms at 65 MHz).
- `clk` in 1: system clock, ~65 MHz.
- `rst` in 1: reset, synchronous, active-high; clock clk.
- `ps2_clk_in` in 1: raw PS/2 clock pin level, asynchronous.
- `ps2_dat_in` in 1: raw PS/2 data pin level, asynchronous.
- `rx_byte` out 8: last received byte; held until the next good frame.
- `rx_stb` out 1: one-cycle pulse; `rx_byte` is new.
- `rx_err` out 1: one-cycle pulse on a framing, parity or timeout error.
- `busy` out 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- **Input conditioning:** each input passes through a 2-FF synchronizer, then a filter.
  - Filter output resets to 1.
  - The output takes the synchronized value only after FILT_LEN consecutive cycles at that value differing from the current output.
- **Edge detect:** `fall` = filtered clock was 1 last cycle and is 0 now. All data sampling happens on `fall`, using the filtered data.
- **State machine:**
  - IDLE: on `fall` with data=0 (start bit) → DATA, bit counter=0. On `fall` with data=1 → `rx_err` pulse, stay IDLE.
  - DATA: on `fall`, shift data in LSB-first into the shift register and increment the counter. After the 8th bit → PARITY.
  - PARITY: on `fall`, capture the parity bit → STOP.
  - STOP: on `fall`:
    - Stop bit=1 and parity ok → load `rx_byte`, pulse `rx_stb`.
    - Otherwise → pulse `rx_err`.
    - In both cases → IDLE.
- **Timeout counter:**
  - Cleared on every `fall` and whenever in IDLE; increments otherwise.
  - On reaching all-ones outside IDLE → `rx_err` pulse, → IDLE, shift register and partial byte discarded.
  - If timeout and `fall` occur in the same cycle, `fall` wins (counter clears, frame continues).
- **Mutual exclusion:** `rx_stb` and `rx_err` are never high in the same cycle.
- **Reset:** reset mid-frame discards the partial frame, and no pulse is emitted. The next frame must begin with a fresh start bit.

## Timing
- Reset values:
  - `rx_byte`=8'h00, `rx_stb`=0, `rx_err`=0, `busy`=0.
  - State=IDLE; filters output 1; counters 0.
- Latency from a raw pin transition to filtered change: 2 (sync) + FILT_LEN cycles.
- `rx_stb`/`rx_err` assert on the cycle after the `fall` that completes or fails the frame. All outputs are registered.
- `rx_byte` changes only in the same cycle `rx_stb` rises; it is stable for at least a full frame (~0.5 ms) afterwards. Consumers need no handshake.
- `busy` rises the cycle after the start-bit `fall` and falls together with the strobe or error pulse.

## Configuration
- `FPGA_ROBOTS_GAME_PS2_PARITY_EN` defined: the parity bit must make the 9 bits (data+parity) odd. If not, a good-stop frame produces `rx_err` and no `rx_stb`.
- Undefined: the parity bit is sampled and ignored. Only the start, stop and timeout checks apply.

## Structure
- Shared package `fpga_robots_game_pkg` holds:
  - the state encoding constants (`PS2_IDLE`, `PS2_DATA`, `PS2_PARITY`, `PS2_STOP`, 2 bits);
  - the frame-length constant (11).
- Sub-module `fpga_robots_game_ps2_filter` (synchronizer + FILT_LEN filter, 1-bit in/out) is instantiated twice, for clock and data.

## Test plan
Bench models the device at ~12.5 kHz (PS/2 clock period ≈ 5200 cycles), data changing mid-high.
- **Good frame:** byte 8'h1C, parity 0, stop 1 → exactly one `rx_stb`, `rx_byte`=8'h1C, no `rx_err`. Then 8'hF0, 8'h1C back-to-back → two strobes with matching bytes.
- **Bad parity:** byte 8'h1C with parity 1 → with PARITY_EN: one `rx_err`, no `rx_stb`, `rx_byte` unchanged. Without PARITY_EN: `rx_stb` with 8'h1C.
- **Bad stop bit:** byte 8'h29 with stop bit 0 → `rx_err` pulse, no strobe, state IDLE; the following good frame 8'h29 strobes normally.
- **Stalled frame:** stop after 4 data bits and hold the clock high for 2^TIMEOUT_W cycles → single `rx_err`, `busy`→0. The next full frame 8'h5A → `rx_stb`, `rx_byte`=8'h5A.
- **Glitch rejection:** low pulses on `ps2_clk_in` of FILT_LEN−1 cycles in IDLE and mid-frame → no state change, no pulses; the frame still decodes correctly.
- **Reset mid-frame:** assert `rst` after 6 data bits → all outputs at reset values; the remainder of that frame (sampled as IDLE, data=1 bits) gives at most `rx_err` pulses and no `rx_stb`; the subsequent good frame decodes.

Source files
------------

// File: rtl/fpga_robots_game_pkg.sv
// Shared definitions for the robots game PS/2 receiver.
// State encoding, frame length and the odd-parity helper.
package fpga_robots_game_pkg;

  typedef enum logic [1:0] {
    PS2_IDLE   = 2'd0,
    PS2_DATA   = 2'd1,
    PS2_PARITY = 2'd2,
    PS2_STOP   = 2'd3
  } ps2_state_e;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_LEN = 11;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/fpga_robots_game_ps2_filter.sv
// Two-flop synchronizer followed by a persistence filter: the output only
// follows the synchronized input after FILT_LEN consecutive differing cycles.
module fpga_robots_game_ps2_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [1:0] sync;
  logic [3:0] cnt;

  // bring the asynchronous pin into the clk domain; idle bus level is 1
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], din};
  end

  // count cycles the synchronized level disagrees with the output; any
  // agreeing cycle restarts the count, so short glitches never get through
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 1'b1;
      cnt  <= '0;
    end else if (sync[1] == dout) begin
      cnt  <= '0;
    end else if (cnt == 4'(FILT_LEN - 1)) begin
      dout <= sync[1];
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/fpga_robots_game_ps2_rx.sv
// Receive-only PS/2 keyboard deframer for the robots game.
// Conditions both pins, samples data on filtered clock falling edges and
// delivers each good scan-code byte with a one-cycle strobe.
// Build option: define FPGA_ROBOTS_GAME_PS2_PARITY_EN to enforce odd parity;
// otherwise the parity bit is sampled and ignored.
module fpga_robots_game_ps2_rx
  import fpga_robots_game_pkg::*;
#(
  parameter int FILT_LEN  = 8,
  parameter int TIMEOUT_W = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] rx_byte,
  output logic       rx_stb,
  output logic       rx_err,
  output logic       busy
);

  logic                 clk_f, dat_f, clk_f_q, fall;
  logic                 tmo_hit, frame_ok;
  logic [TIMEOUT_W-1:0] tmo;
  logic [7:0]           shreg;
  logic [2:0]           bit_cnt;
  ps2_state_e           state;
`ifdef FPGA_ROBOTS_GAME_PS2_PARITY_EN
  logic                 par_bit;
`endif

  fpga_robots_game_ps2_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk (clk), .rst (rst), .din (ps2_clk_in), .dout (clk_f)
  );

  fpga_robots_game_ps2_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
    .clk (clk), .rst (rst), .din (ps2_dat_in), .dout (dat_f)
  );

  assign fall    = clk_f_q & ~clk_f;
  assign tmo_hit = &tmo;

  // stop-bit check, plus parity when enforced
`ifdef FPGA_ROBOTS_GAME_PS2_PARITY_EN
  assign frame_ok = dat_f & odd_parity_ok(shreg, par_bit);
`else
  assign frame_ok = dat_f;
`endif

  // previous filtered clock level for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) clk_f_q <= 1'b1;
    else     clk_f_q <= clk_f;
  end

  // inter-edge watchdog: only runs while a frame is open
  always_ff @(posedge clk) begin
    if (rst || state == PS2_IDLE || fall) tmo <= '0;
    else                                  tmo <= tmo + TIMEOUT_W'(1);
  end

  // frame state machine; a falling edge always beats a same-cycle timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PS2_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      rx_byte <= 8'h00;
      rx_stb  <= 1'b0;
      rx_err  <= 1'b0;
      busy    <= 1'b0;
`ifdef FPGA_ROBOTS_GAME_PS2_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      rx_stb <= 1'b0;
      rx_err <= 1'b0;
      if (state != PS2_IDLE && !fall && tmo_hit) begin
        state   <= PS2_IDLE;
        busy    <= 1'b0;
        rx_err  <= 1'b1;
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (fall) begin
        case (state)
          PS2_IDLE: begin
            if (!dat_f) begin
              state   <= PS2_DATA;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end else begin
              rx_err  <= 1'b1;
            end
          end
          PS2_DATA: begin
            shreg   <= {dat_f, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PS2_PARITY;
          end
          PS2_PARITY: begin
`ifdef FPGA_ROBOTS_GAME_PS2_PARITY_EN
            par_bit <= dat_f;
`endif
            state   <= PS2_STOP;
          end
          PS2_STOP: begin
            state <= PS2_IDLE;
            busy  <= 1'b0;
            if (frame_ok) begin
              rx_byte <= shreg;
              rx_stb  <= 1'b1;
            end else begin
              rx_err  <= 1'b1;
            end
          end
          default: begin
            state <= PS2_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpga_robots_game_ps2_rx.sv
// Directed bench for the PS/2 receiver. The device model runs a fast PS/2
// clock and a short timeout so the whole sequence stays small.
module tb_fpga_robots_game_ps2_rx;
  import fpga_robots_game_pkg::*;

  localparam int HALF = 40;
  localparam int FILT = 8;
  localparam int TW   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_dat_in = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_stb, rx_err, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         n_err = 0, n_mutex = 0, n_busy_stb = 0;
  int         err_base = 0;
  logic [7:0] last_good = 8'h00;

  fpga_robots_game_ps2_rx #(.FILT_LEN(FILT), .TIMEOUT_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .rx_byte    (rx_byte),
    .rx_stb     (rx_stb),
    .rx_err     (rx_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // output monitor: collect strobed bytes and pulse events
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_stb) begin
        got_q.push_back(rx_byte);
        if (busy) n_busy_stb++;
      end
      if (rx_err) n_err++;
      if (rx_stb && rx_err) n_mutex++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // one PS/2 bit: data changes mid-high, then clock low for half a period
  task automatic send_bit(input logic b, input logic glitch);
    if (glitch) begin
      cyc(12); ps2_clk_in = 1'b0; cyc(FILT - 1); ps2_clk_in = 1'b1; cyc(12);
    end
    cyc(HALF / 2); ps2_dat_in = b;
    cyc(HALF / 2); ps2_clk_in = 1'b0;
    cyc(HALF);     ps2_clk_in = 1'b1;
  endtask

  // frame bits first..last (0 = start, 10 = stop); glitch before bit glitch_at
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int first, input int last, input int glitch_at);
    logic [PS2_FRAME_LEN-1:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = first; i <= last; i++) send_bit(bits[i], i == glitch_at);
    cyc(HALF);
    ps2_dat_in = 1'b1;
  endtask

  task automatic end_phase(input string tag, input int exp_errs);
    cyc(30);
    check({tag, "_nstb"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    check({tag, "_nerr"}, 32'(n_err - err_base), 32'(exp_errs));
    check({tag, "_hold"}, 32'(rx_byte), 32'(last_good));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    err_base = n_err;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte"}, 32'(rx_byte), 32'h00);
    check({tag, "_stb"},  32'(rx_stb),  32'd0);
    check({tag, "_err"},  32'(rx_err),  32'd0);
    check({tag, "_busy"}, 32'(busy),    32'd0);
  endtask

  initial begin
    cyc(5);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    cyc(20);
    err_base = n_err;

    // good frame
    exp_q.push_back(8'h1C); last_good = 8'h1C;
    send_frame(8'h1C, 1'b0, 1'b1, 0, 10, -1);
    end_phase("good", 0);

    // back-to-back frames
    exp_q.push_back(8'hF0); exp_q.push_back(8'h1C); last_good = 8'h1C;
    send_frame(8'hF0, 1'b1, 1'b1, 0, 10, -1);
    send_frame(8'h1C, 1'b0, 1'b1, 0, 10, -1);
    end_phase("b2b", 0);

    // bad parity
`ifdef FPGA_ROBOTS_GAME_PS2_PARITY_EN
    send_frame(8'h1C, 1'b1, 1'b1, 0, 10, -1);
    end_phase("badpar", 1);
`else
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b1, 1'b1, 0, 10, -1);
    end_phase("badpar", 0);
`endif

    // bad stop bit, then recovery
    send_frame(8'h29, 1'b0, 1'b0, 0, 10, -1);
    end_phase("badstop", 1);
    exp_q.push_back(8'h29); last_good = 8'h29;
    send_frame(8'h29, 1'b0, 1'b1, 0, 10, -1);
    end_phase("after_stop", 0);

    // stalled frame: start + 4 data bits, then clock held high
    send_frame(8'h5A, 1'b1, 1'b1, 0, 4, -1);
    cyc(20);
    check("stall_busy", 32'(busy), 32'd1);
    cyc(1 << TW);
    end_phase("stall", 1);
    exp_q.push_back(8'h5A); last_good = 8'h5A;
    send_frame(8'h5A, 1'b1, 1'b1, 0, 10, -1);
    end_phase("after_stall", 0);

    // glitch rejection in idle and mid-frame
    ps2_clk_in = 1'b0; cyc(FILT - 1); ps2_clk_in = 1'b1;
    cyc(50);
    check("glitch_idle_busy", 32'(busy), 32'd0);
    check("glitch_idle_err", 32'(n_err - err_base), 32'd0);
    exp_q.push_back(8'hA5); last_good = 8'hA5;
    send_frame(8'hA5, 1'b1, 1'b1, 0, 10, 4);
    end_phase("glitch", 0);

    // reset after 6 data bits
    send_frame(8'hC3, 1'b1, 1'b1, 0, 6, -1);
    @(posedge clk); rst = 1'b1;
    cyc(2);
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    last_good = 8'h00;
    cyc(5);
    err_base = n_err;
    got_q.delete();
    send_frame(8'hC3, 1'b1, 1'b1, 7, 10, -1);
    cyc(30);
    check("midrst_nostb", 32'(got_q.size()), 32'd0);
    check("midrst_errs_le4", 32'((n_err - err_base) <= 4), 32'd1);
    got_q.delete();
    err_base = n_err;
    exp_q.push_back(8'h1C); last_good = 8'h1C;
    send_frame(8'h1C, 1'b0, 1'b1, 0, 10, -1);
    end_phase("after_rst", 0);

    check("mutex", 32'(n_mutex), 32'd0);
    check("busy_at_stb", 32'(n_busy_stb), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
